sr_load_arbiter: RTL and testbench
==================================

# sr_load_arbiter

Controller and arbiter for the 16-bit enabled serial shift register: two requesters each present a parallel word, the block grants the register round-robin, and serialises the granted word into it MSB-first by driving the register's `in` and `en` pins. When `done` pulses, the shift register's parallel output equals the granted word, bit for bit. The block sits between the game and display logic and the shift register, and is the only driver of the register's `in` and `en`.

## Interface
Parameters:
- `WIDTH`, default 16: length of the controlled shift register and of each data word.

Ports:
- `clk` (in, 1): sole clock; all state updates on rising edge.
- `reset` (in, 1): asynchronous, active-high; also wired to the shift register's `reset`.
- `req0` (in, 1): requester 0 wants a load; held high with `data0` stable until `ack0`.
- `data0` (in, WIDTH): word from requester 0.
- `req1` (in, 1): requester 1 load request; same rules.
- `data1` (in, WIDTH): word from requester 1.
- `ack0` (out, 1): one-cycle pulse; requester 0's word has been captured.
- `ack1` (out, 1): one-cycle pulse; requester 1's word has been captured.
- `sr_in` (out, 1): serial data to the shift register `in`.
- `sr_en` (out, 1): shift enable to the shift register `en`.
- `busy` (out, 1): high in SHIFT and DONE.
- `done` (out, 1): one-cycle pulse; the load is complete.
- `owner` (out, 1): id of the most recent grant; valid from `ack` until the next grant.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If no request is active, stay in IDLE.
  - If a request is active, grant one requester:
    - If only one is requesting, grant it.
    - If both are requesting, grant the one not granted last. `last` resets to 1, so requester 0 wins the first tie.
  - On the edge that grants:
    - Capture the selected data into the internal `shreg`.
    - Set `owner` and `last` to the granted id.
    - Clear the bit counter.
    - Go to SHIFT.
- SHIFT:
  - `sr_en` = 1 and `sr_in` = `shreg[WIDTH-1]`.
  - Each edge shifts `shreg` left by one (zero fill) and increments the counter.
  - On the edge where the counter equals WIDTH-1, go to DONE.
  - Exactly WIDTH shift cycles occur.
- DONE:
  - `done` = 1 for one cycle, `sr_en` = 0.
  - Always go to IDLE next; there is no arbitration in DONE.
- Outside SHIFT, `sr_en` = 0 and `sr_in` = 0.
- `ackN` is registered and is high only during the first SHIFT cycle of requester N's grant.
- A request that is high during SHIFT or DONE is not acked. It is considered at the next IDLE cycle.
- A requester must drop `req` the cycle after seeing `ack`. A `req` still high in the next IDLE is treated as a new request.
- Counter width is clog2(WIDTH)+1. The counter never wraps during a load.

## Timing
- Reset values (asynchronous, take effect immediately, including mid-SHIFT):
  - state = IDLE, `shreg` = 0, counter = 0, `owner` = 0, `last` = 1.
  - `ack0`, `ack1`, `sr_in`, `sr_en`, `busy`, `done` = 0.
- The external shift register clears under the same reset, so an aborted load leaves it at all zeros.
- Latency, with cycle 0 the IDLE cycle in which `req` is seen:
  - `ack` and `sr_en` rise in cycle 1.
  - `sr_en` is high for cycles 1..WIDTH.
  - `done` is high in cycle WIDTH+1.
  - The next grant can be made in cycle WIDTH+2.
  - Minimum load period is WIDTH+2 cycles (18 at default).
- Bit order: in SHIFT cycle k (k = 0..WIDTH-1), `sr_in` = captured `data[WIDTH-1-k]`. After the last shift, register `out[i]` = `data[i]`.
- When both requests are continuously high, grants alternate 0,1,0,1,… and neither requester waits more than one load.

## Test plan
- Reset, then `req0` with `data0` = 16'hA5C3:
  - `ack0` is high in cycle 1 only.
  - `sr_en` is high in cycles 1–16.
  - `done` is high in cycle 17, `owner` = 0, and the shift register output = 16'hA5C3.
- `req0` and `req1` raised in the same cycle with `data0` = 16'h1234 and `data1` = 16'hBEEF:
  - Requester 0 is served first; output = 16'h1234 at the first `done`.
  - `ack1` follows in cycle 19; output = 16'hBEEF at the second `done`, `owner` = 1.
- Both requesters held continuously for 6 loads (each re-raising `req` the cycle after `ack`): `ack` order is 0,1,0,1,0,1, and consecutive `done` pulses are exactly 18 cycles apart.
- `req1` raised mid-SHIFT of a requester 0 load: no `ack1` until the IDLE cycle after `done`, then `ack1` in the following cycle.
- `reset` asserted after 5 shifts of 16'hFFFF:
  - `sr_en`, `busy`, and `ack` drop without waiting for a clock edge.
  - The shift register reads 16'h0000.
  - No `done` occurs.
  - A new `req0` after release completes normally.
- `req0` with 16'h0001 and then 16'h8000: the output ends at 16'h0001 and then 16'h8000, with no stale bits from the previous load.

Source files
------------

// File: rtl/sr_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_load_arbiter
// Purpose  : Round-robin arbiter and serialiser for a WIDTH-bit enabled serial
//            shift register. Two requesters each present a parallel word; the
//            granted word is shifted into the register MSB-first through its
//            `in` and `en` pins. When `done` pulses, the register's parallel
//            output equals the granted word.
// Ports    : clk, reset (async, active-high)
//            req0/data0, req1/data1 : load requests and their words
//            ack0/ack1              : one-cycle capture acknowledge pulses
//            sr_in/sr_en            : serial data and enable to the register
//            busy                   : high while shifting or completing
//            done                   : one-cycle load-complete pulse
//            owner                  : id of the most recent grant
// Revision : 1.0 - initial release
// ============================================================================
module sr_load_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             sr_in,
  output logic             sr_en,
  output logic             busy,
  output logic             done,
  output logic             owner
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               grant0, grant1;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last wins. last_q resets to 1 so requester 0 takes the
  // first tie.
  always_comb begin
    grant0 = req0 & (~req1 | last_q);
    grant1 = req1 & (~req0 | ~last_q);
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          shreg_d = grant1 ? data1 : data0;
          owner_d = grant1;
          last_d  = grant1;
          cnt_d   = '0;
          ack0_d  = grant0;
          ack1_d  = grant1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // No arbitration here: a pending request is seen in the next IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Outputs decode directly from registered state so an asynchronous reset
  // drops them immediately, without waiting for a clock edge.
  always_comb begin
    sr_en = (state_q == SHIFT);
    sr_in = (state_q == SHIFT) & shreg_q[WIDTH-1];
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    owner = owner_q;
    ack0  = ack0_q;
    ack1  = ack1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_load_arbiter
// Purpose  : Self-checking bench for sr_load_arbiter. A behavioural shift
//            register sits on sr_in/sr_en; a cycle-phase reference model
//            predicts every output each cycle from the load latency rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_load_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] data0, data1;
  logic         ack0, ack1, sr_in, sr_en, busy, done, owner;
  logic [W-1:0] sr_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = idle, 1..W = shift cycle k+1, W+1 = done.
  int           m_phase;
  logic         m_last;
  logic         m_owner;
  logic [W-1:0] m_word;
  int           cyc;
  int           last_done_cyc;

  always #5 clk = ~clk;

  sr_load_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .ack0  (ack0),
    .ack1  (ack1),
    .sr_in (sr_in),
    .sr_en (sr_en),
    .busy  (busy),
    .done  (done),
    .owner (owner)
  );

  // Behavioural model of the external enabled shift register.
  always @(posedge clk or posedge reset) begin
    if (reset) sr_out <= '0;
    else if (sr_en) sr_out <= {sr_out[W-2:0], sr_in};
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    m_owner = 1'b0;
    m_word  = '0;
  endtask

  // One clock cycle. mode 0: random requesters; mode 1: bench-driven requests
  // (dropped on ack only); mode 2: both re-raise the cycle after their ack.
  task automatic step(input int mode);
    logic       g;
    logic       e_en, e_in, e_a0, e_a1, e_busy, e_done;
    // Model advances on the edge using the request levels now being driven.
    if (m_phase == 0) begin
      if (req0 || req1) begin
        g       = (req0 && req1) ? ~m_last : req1;
        m_owner = g;
        m_last  = g;
        m_word  = g ? data1 : data0;
        m_phase = 1;
      end
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end

    @(posedge clk);
    #1;
    cyc++;
    e_en   = (m_phase >= 1) && (m_phase <= W);
    e_in   = e_en ? m_word[W-m_phase] : 1'b0;
    e_a0   = (m_phase == 1) && (m_owner == 1'b0);
    e_a1   = (m_phase == 1) && (m_owner == 1'b1);
    e_busy = (m_phase != 0);
    e_done = (m_phase == W + 1);
    check_val("outs{ack0,ack1,en,in,busy,done}",
              {26'd0, ack0, ack1, sr_en, sr_in, busy, done},
              {26'd0, e_a0, e_a1, e_en, e_in, e_busy, e_done});
    if (e_done) begin
      check_val("sr_out_at_done", sr_out, m_word);
      check_val("owner_at_done", owner, m_owner);
      if (mode == 2 && last_done_cyc > 0)
        check_val("done_spacing", cyc - last_done_cyc, W + 2);
      last_done_cyc = cyc;
    end

    // Requester behaviour: drop on ack, optionally raise a fresh request.
    if (e_a0) req0 = 1'b0;
    else if (!req0 && (mode == 2 || (mode == 0 && $urandom_range(3) == 0))) begin
      req0  = 1'b1;
      data0 = W'($urandom);
    end
    if (e_a1) req1 = 1'b0;
    else if (!req1 && (mode == 2 || (mode == 0 && $urandom_range(3) == 0))) begin
      req1  = 1'b1;
      data1 = W'($urandom);
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(mode);
  endtask

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    cyc   = 0;
    last_done_cyc = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outs", {ack0, ack1, sr_en, sr_in, busy, done, owner}, 7'd0);
    check_val("reset_sr_out", sr_out, 32'd0);
    reset = 1'b0;

    // Single load from requester 0.
    req0 = 1'b1; data0 = 16'hA5C3;
    run(W + 3, 1);

    // Simultaneous requests: 0 first, then 1.
    req0 = 1'b1; data0 = 16'h1234;
    req1 = 1'b1; data1 = 16'hBEEF;
    run(2 * (W + 2) + 2, 1);

    // Both held continuously: alternating grants, 18-cycle done spacing.
    last_done_cyc = 0;
    run(6 * (W + 2) + 2, 2);
    run(2 * (W + 2) + 2, 1);

    // req1 arriving mid-shift of a requester 0 load.
    req0 = 1'b1; data0 = 16'h5A5A;
    run(6, 1);
    req1 = 1'b1; data1 = 16'h0F0F;
    run(2 * (W + 2) + 2, 1);

    // Asynchronous reset after 5 shifts of all ones.
    req0 = 1'b1; data0 = 16'hFFFF;
    run(6, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_outs", {ack0, ack1, sr_en, busy, done}, 5'd0);
    check_val("async_reset_sr_out", sr_out, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run(3, 1);
    req0 = 1'b1; data0 = 16'h3C96;
    run(W + 3, 1);

    // Back-to-back loads leave no stale bits.
    req0 = 1'b1; data0 = 16'h0001;
    run(W + 3, 1);
    req0 = 1'b1; data0 = 16'h8000;
    run(W + 3, 1);

    // Random traffic, then drain.
    run(2000, 0);
    run(2 * (W + 2) + 4, 1);
    check_val("idle_after_drain", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
